id_ex_hazard_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage RV32I pipeline, with load-use hazard detection and branch-flush handling.
- Captures decoded operands and controls from ID and presents them to EX.
- Its ex_aluop, ex_funct7 and ex_funct3 outputs drive the EX-stage ALU operation decoder directly.
- Also drives the PC and IF/ID write enables and the IF/ID flush, and keeps saturating bubble/flush counters for performance debug.

---
 rtl/id_ex_hazard_stage.sv | 84 ++++++++
 tb/tb_id_ex_hazard_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: ID/EX pipeline register with load-use stall, branch flush and saturating perf counters.
module id_ex_hazard_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [1:0]        id_aluop,
  input  logic [6:0]        id_funct7,
  input  logic [2:0]        id_funct3,
  input  logic [5:0]        id_ctrl,
  input  logic              hold,
  input  logic              flush,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [REG_W-1:0]  ex_rs1,
  output logic [REG_W-1:0]  ex_rs2,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [1:0]        ex_aluop,
  output logic [6:0]        ex_funct7,
  output logic [2:0]        ex_funct3,
  output logic [5:0]        ex_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic w_load_use, w_kill;
  // rs2 is compared for every format; an I-type false match only costs one bubble
  assign w_load_use = ex_valid & ex_ctrl[4] & (ex_rd != '0) & id_valid &
                      ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign w_kill     = flush | w_load_use;
  assign pc_write   = ~hold & (flush | ~w_load_use);
  assign ifid_write = pc_write;
  assign ifid_flush = ~hold & flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_rd1     <= '0;
      ex_rd2     <= '0;
      ex_imm     <= '0;
      ex_aluop   <= '0;
      ex_funct7  <= '0;
      ex_funct3  <= '0;
      ex_ctrl    <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (!hold) begin
      ex_valid   <= w_kill ? 1'b0 : id_valid;
      ex_pc      <= w_kill ? '0 : id_pc;
      ex_rs1     <= w_kill ? '0 : id_rs1;
      ex_rs2     <= w_kill ? '0 : id_rs2;
      ex_rd      <= w_kill ? '0 : id_rd;
      ex_rd1     <= w_kill ? '0 : id_rd1;
      ex_rd2     <= w_kill ? '0 : id_rd2;
      ex_imm     <= w_kill ? '0 : id_imm;
      ex_funct7  <= w_kill ? '0 : id_funct7;
      ex_funct3  <= w_kill ? '0 : id_funct3;
      ex_aluop   <= (w_kill | ~id_valid) ? '0 : id_aluop;
      ex_ctrl    <= (w_kill | ~id_valid) ? '0 : id_ctrl;
      if (flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
      if (!flush && w_load_use && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// tb_id_ex_hazard_stage: directed checks of capture, load-use stall, flush, hold, reset and counter saturation.
module tb_id_ex_hazard_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_rd1 = '0, id_rd2 = '0, id_imm = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [1:0]  id_aluop = '0;
  logic [6:0]  id_funct7 = '0;
  logic [2:0]  id_funct3 = '0;
  logic [5:0]  id_ctrl = '0;
  logic        hold = 1'b0, flush = 1'b0;
  logic        pc_write, ifid_write, ifid_flush, ex_valid;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [1:0]  ex_aluop;
  logic [6:0]  ex_funct7;
  logic [2:0]  ex_funct3;
  logic [5:0]  ex_ctrl;
  logic [15:0] bubble_cnt, flush_cnt;
  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_ex_valid;
  logic [31:0] s_ex_pc, s_ex_rd1, s_ex_rd2, s_ex_imm;
  logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [1:0]  s_ex_aluop;
  logic [6:0]  s_ex_funct7;
  logic [2:0]  s_ex_funct3;
  logic [5:0]  s_ex_ctrl;
  logic [3:0]  s_bubble_cnt, s_flush_cnt;
  int          n_tests = 0, n_fail = 0;
  localparam logic [5:0] LW_CTRL  = 6'b110110;
  localparam logic [5:0] ADD_CTRL = 6'b000100;
  always #5 clk = ~clk;
  id_ex_hazard_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_aluop(id_aluop),
    .id_funct7(id_funct7), .id_funct3(id_funct3), .id_ctrl(id_ctrl), .hold(hold), .flush(flush),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_aluop(ex_aluop), .ex_funct7(ex_funct7), .ex_funct3(ex_funct3),
    .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );
  // narrow-counter copy so saturation is reachable in a short run
  id_ex_hazard_stage #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_aluop(id_aluop),
    .id_funct7(id_funct7), .id_funct3(id_funct3), .id_ctrl(id_ctrl), .hold(hold), .flush(flush),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush), .ex_valid(s_ex_valid),
    .ex_pc(s_ex_pc), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_rd1(s_ex_rd1),
    .ex_rd2(s_ex_rd2), .ex_imm(s_ex_imm), .ex_aluop(s_ex_aluop), .ex_funct7(s_ex_funct7),
    .ex_funct3(s_ex_funct3), .ex_ctrl(s_ex_ctrl), .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [1:0] op, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [5:0] ctrl);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rd1 = pc ^ 32'h1111_0000; id_rd2 = pc ^ 32'h2222_0000; id_imm = pc ^ 32'h0000_0ABC;
    id_aluop = op; id_funct7 = f7; id_funct3 = f3; id_ctrl = ctrl;
    #1;
  endtask
  initial begin
    #12 rst_n = 1'b1;
    tick();
    drive(1, 32'h100, 5'd1, 5'd2, 5'd3, 2'b10, 7'h20, 3'b000, ADD_CTRL);
    tick();
    chk("cap_pc", ex_pc, 32'h100);
    chk("cap_rd2", ex_rd2, 32'h2222_0100);
    chk("cap_f7", {25'd0, ex_funct7}, 32'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc", ex_pc, 32'h0);
    chk("rst_valid", {31'd0, ex_valid}, 32'h0);
    chk("rst_ctrl", {26'd0, ex_ctrl}, 32'h0);
    chk("rst_cnt", {bubble_cnt, flush_cnt}, 32'h0);
    chk("rst_en", {29'd0, pc_write, ifid_write, ifid_flush}, 32'b110);
    #1 rst_n = 1'b1;
    // load-use: LW x5 then ADD x7,x5,x6
    drive(1, 32'h200, 5'd1, 5'd0, 5'd5, 2'b00, 7'h12, 3'b010, LW_CTRL);
    tick();
    drive(1, 32'h204, 5'd5, 5'd6, 5'd7, 2'b10, 7'h00, 3'b000, ADD_CTRL);
    chk("lu_en", {29'd0, pc_write, ifid_write, ifid_flush}, 32'b000);
    tick();
    chk("lu_bub_valid", {31'd0, ex_valid}, 32'h0);
    chk("lu_bub_ctrl", {26'd0, ex_ctrl}, 32'h0);
    chk("lu_bubble_cnt", {16'd0, bubble_cnt}, 32'd1);
    chk("lu_after_en", {29'd0, pc_write, ifid_write, ifid_flush}, 32'b110);
    tick();
    chk("lu_add_valid", {31'd0, ex_valid}, 32'h1);
    chk("lu_add_op", {23'd0, ex_aluop, ex_funct7}, {23'd0, 2'b10, 7'h00});
    chk("lu_add_f3", {29'd0, ex_funct3}, 32'h0);
    chk("lu_add_pc", ex_pc, 32'h204);
    chk("lu_bubble_once", {16'd0, bubble_cnt}, 32'd1);
    // no false stall: load to x0, and load to x5 with unrelated sources
    drive(1, 32'h208, 5'd1, 5'd0, 5'd0, 2'b00, 7'h00, 3'b010, LW_CTRL);
    tick();
    drive(1, 32'h20C, 5'd0, 5'd0, 5'd8, 2'b10, 7'h00, 3'b000, ADD_CTRL);
    chk("nfs_x0_en", {29'd0, pc_write, ifid_write, ifid_flush}, 32'b110);
    tick();
    drive(1, 32'h210, 5'd1, 5'd0, 5'd5, 2'b00, 7'h00, 3'b010, LW_CTRL);
    tick();
    drive(1, 32'h214, 5'd6, 5'd7, 5'd9, 2'b10, 7'h00, 3'b000, ADD_CTRL);
    chk("nfs_x5_en", {29'd0, pc_write, ifid_write, ifid_flush}, 32'b110);
    tick();
    chk("nfs_pc", ex_pc, 32'h214);
    chk("nfs_bubble_cnt", {16'd0, bubble_cnt}, 32'd1);
    // flush beats stall
    drive(1, 32'h218, 5'd1, 5'd0, 5'd5, 2'b00, 7'h00, 3'b010, LW_CTRL);
    tick();
    drive(1, 32'h21C, 5'd5, 5'd0, 5'd9, 2'b10, 7'h00, 3'b000, ADD_CTRL);
    flush = 1'b1;
    #1;
    chk("fl_en", {29'd0, pc_write, ifid_write, ifid_flush}, 32'b111);
    tick();
    flush = 1'b0;
    chk("fl_valid", {31'd0, ex_valid}, 32'h0);
    chk("fl_fields", ex_pc | ex_imm | {27'd0, ex_rd}, 32'h0);
    chk("fl_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    chk("fl_bubble_cnt", {16'd0, bubble_cnt}, 32'd1);
    // hold beats flush and load-use for three cycles
    drive(1, 32'h300, 5'd1, 5'd0, 5'd5, 2'b00, 7'h00, 3'b010, LW_CTRL);
    tick();
    drive(1, 32'h304, 5'd5, 5'd0, 5'd9, 2'b10, 7'h00, 3'b000, ADD_CTRL);
    flush = 1'b1;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_en", {29'd0, pc_write, ifid_write, ifid_flush}, 32'b000);
      tick();
      chk("hold_pc", ex_pc, 32'h300);
      chk("hold_rd", {27'd0, ex_rd}, 32'd5);
      chk("hold_cnt", {bubble_cnt, flush_cnt}, {16'd1, 16'd1});
    end
    hold = 1'b0;
    #1;
    chk("unhold_en", {29'd0, pc_write, ifid_write, ifid_flush}, 32'b111);
    tick();
    flush = 1'b0;
    chk("unhold_pc", ex_pc, 32'h0);
    chk("unhold_cnt", {bubble_cnt, flush_cnt}, {16'd1, 16'd2});
    // invalid ID: data captured, controls zeroed
    drive(0, 32'h400, 5'd3, 5'd4, 5'd6, 2'b10, 7'h20, 3'b101, 6'h3F);
    tick();
    chk("inv_valid", {31'd0, ex_valid}, 32'h0);
    chk("inv_ctrl_op", {24'd0, ex_ctrl, ex_aluop}, 32'h0);
    chk("inv_pc", ex_pc, 32'h400);
    chk("inv_imm", ex_imm, 32'h0000_0EBC);
    chk("inv_f3", {29'd0, ex_funct3}, 32'd5);
    // saturation on the 4-bit instance; 16-bit instance keeps counting
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h500, 5'd1, 5'd0, 5'd5, 2'b00, 7'h00, 3'b010, LW_CTRL);
      tick();
      drive(1, 32'h504, 5'd0, 5'd5, 5'd9, 2'b10, 7'h00, 3'b000, ADD_CTRL);
      tick();
    end
    chk("sat_bubble_s", {28'd0, s_bubble_cnt}, 32'hF);
    chk("sat_bubble", {16'd0, bubble_cnt}, 32'd21);
    flush = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    flush = 1'b0;
    chk("sat_flush_s", {28'd0, s_flush_cnt}, 32'hF);
    chk("sat_flush", {16'd0, flush_cnt}, 32'd22);
    chk("sat_bubble_s_kept", {28'd0, s_bubble_cnt}, 32'hF);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
